// File: rtl/clksel_ctrl.sv
// rtl/clksel_ctrl.sv - hsclk_sel sequencer for the glitch-free PHI2 clock switch
module clksel_ctrl #(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMEOUT       = 15
) (
    input  logic       lsclk_in,
    input  logic       rst_b,
    input  logic       turbo_en,
    input  logic       host_req,
    input  logic [1:0] cpuclk_div_cfg,
    input  logic       hsclk_selected,
    input  logic       lsclk_selected,
    output logic       hsclk_sel,
    output logic [1:0] cpuclk_div_sel,
    output logic       host_ready,
    output logic       switch_fault,
    output logic [7:0] sw_count,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ST_LS    = 2'b00,
        ST_TO_HS = 2'b01,
        ST_HS    = 2'b10,
        ST_TO_LS = 2'b11
    } state_t;

    localparam logic [3:0] SETTLE_MAX = 4'(SETTLE_CYCLES);
    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] r_hs_sync;
    logic [SYNC_STAGES-1:0] r_ls_sync;
    state_t                 r_state;
    logic                   r_hsclk_sel;
    logic [1:0]             r_div_sel;
    logic [3:0]             r_settle_cnt;
    logic [7:0]             r_to_cnt;
    logic                   r_fault;
    logic [7:0]             r_sw_count;

    state_t                 w_state;
    logic                   w_hsclk_sel;
    logic [1:0]             w_div_sel;
    logic [3:0]             w_settle_cnt;
    logic [7:0]             w_to_cnt;
    logic                   w_fault;
    logic [7:0]             w_sw_count;
    logic                   w_hs_s;
    logic                   w_ls_s;
    logic                   w_hs_ok;
    logic                   w_ls_ok;
    logic                   w_go_hs;

    // Feedback synchronizers reset to "switch is on the low-speed clock".
    always_ff @(posedge lsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            r_hs_sync <= '0;
            r_ls_sync <= '1;
        end else begin
            r_hs_sync <= {r_hs_sync[SYNC_STAGES-2:0], hsclk_selected};
            r_ls_sync <= {r_ls_sync[SYNC_STAGES-2:0], lsclk_selected};
        end
    end

    assign w_hs_s  = r_hs_sync[SYNC_STAGES-1];
    assign w_ls_s  = r_ls_sync[SYNC_STAGES-1];
    assign w_hs_ok = w_hs_s & ~w_ls_s;
    assign w_ls_ok = w_ls_s & ~w_hs_s;
    assign w_go_hs = turbo_en & ~host_req & ~r_fault;

    always_ff @(posedge lsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            r_state      <= ST_LS;
            r_hsclk_sel  <= 1'b0;
            r_div_sel    <= 2'b11;
            r_settle_cnt <= '0;
            r_to_cnt     <= '0;
            r_fault      <= 1'b0;
            r_sw_count   <= '0;
        end else begin
            r_state      <= w_state;
            r_hsclk_sel  <= w_hsclk_sel;
            r_div_sel    <= w_div_sel;
            r_settle_cnt <= w_settle_cnt;
            r_to_cnt     <= w_to_cnt;
            r_fault      <= w_fault;
            r_sw_count   <= w_sw_count;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_hsclk_sel  = r_hsclk_sel;
        w_div_sel    = r_div_sel;
        w_settle_cnt = r_settle_cnt;
        w_to_cnt     = r_to_cnt;
        w_fault      = r_fault;
        w_sw_count   = r_sw_count;
        case (r_state)
            ST_LS: begin
                // Divider may only move while the CPU runs from the host clock.
                w_div_sel = cpuclk_div_cfg;
                if (r_settle_cnt != SETTLE_MAX) begin
                    w_settle_cnt = r_settle_cnt + 4'd1;
                end
                if (r_settle_cnt == SETTLE_MAX && w_go_hs) begin
                    w_state     = ST_TO_HS;
                    w_hsclk_sel = 1'b1;
                    w_to_cnt    = '0;
                end
            end
            ST_TO_HS: begin
                if (!w_go_hs) begin
                    w_state     = ST_TO_LS;
                    w_hsclk_sel = 1'b0;
                    w_to_cnt    = '0;
                end else if (w_hs_ok) begin
                    w_state = ST_HS;
                end else if (r_to_cnt == TO_LAST) begin
                    w_fault     = 1'b1;
                    w_state     = ST_TO_LS;
                    w_hsclk_sel = 1'b0;
                end else begin
                    w_to_cnt = r_to_cnt + 8'd1;
                end
            end
            ST_HS: begin
                if (!w_go_hs) begin
                    w_state     = ST_TO_LS;
                    w_hsclk_sel = 1'b0;
                    w_to_cnt    = '0;
                    if (r_sw_count != 8'hFF) begin
                        w_sw_count = r_sw_count + 8'd1;
                    end
                end
            end
            ST_TO_LS: begin
                // Stay here until the switch confirms LS, even after a timeout.
                if (w_ls_ok) begin
                    w_state      = ST_LS;
                    w_settle_cnt = '0;
                end else if (r_to_cnt == TO_LAST) begin
                    w_fault = 1'b1;
                end else begin
                    w_to_cnt = r_to_cnt + 8'd1;
                end
            end
            default: w_state = ST_LS;
        endcase
    end

    assign hsclk_sel      = r_hsclk_sel;
    assign cpuclk_div_sel = r_div_sel;
    assign host_ready     = (r_state == ST_LS) & host_req;
    assign switch_fault   = r_fault;
    assign sw_count       = r_sw_count;
    assign state_dbg      = r_state;

endmodule

// File: tb/tb_clksel_ctrl.sv
// tb/tb_clksel_ctrl.sv - self-checking bench for clksel_ctrl
module tb_clksel_ctrl;

    localparam int SYNC_STAGES   = 2;
    localparam int SETTLE_CYCLES = 2;
    localparam int TIMEOUT       = 15;

    logic       lsclk_in = 1'b0;
    logic       rst_b;
    logic       turbo_en;
    logic       host_req;
    logic [1:0] cpuclk_div_cfg;
    logic       hsclk_selected;
    logic       lsclk_selected;
    logic       hsclk_sel;
    logic [1:0] cpuclk_div_sel;
    logic       host_ready;
    logic       switch_fault;
    logic [7:0] sw_count;
    logic [1:0] state_dbg;

    int sw_mode = 0;
    int n_checks = 0;
    int n_pass = 0;

    clksel_ctrl #(
        .SYNC_STAGES(SYNC_STAGES), .SETTLE_CYCLES(SETTLE_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .lsclk_in(lsclk_in), .rst_b(rst_b), .turbo_en(turbo_en), .host_req(host_req),
        .cpuclk_div_cfg(cpuclk_div_cfg), .hsclk_selected(hsclk_selected),
        .lsclk_selected(lsclk_selected), .hsclk_sel(hsclk_sel),
        .cpuclk_div_sel(cpuclk_div_sel), .host_ready(host_ready),
        .switch_fault(switch_fault), .sw_count(sw_count), .state_dbg(state_dbg)
    );

    always #5 lsclk_in = ~lsclk_in;

    // Clock switch: mode 0 follows the request instantly, mode 1 never leaves LS.
    assign hsclk_selected = (sw_mode == 0) ? hsclk_sel : 1'b0;
    assign lsclk_selected = (sw_mode == 0) ? ~hsclk_sel : 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    localparam int M_LS = 0, M_TO_HS = 1, M_HS = 2, M_TO_LS = 3;
    int       m_phase = M_LS;
    bit       m_sel = 0;
    bit [1:0] m_div = 2'b11;
    int       m_settle = 0;
    int       m_wait = 0;
    bit       m_fault = 0;
    int       m_switches = 0;
    bit       m_hs_line[SYNC_STAGES];
    bit       m_ls_line[SYNC_STAGES];

    task automatic model_reset();
        m_phase = M_LS; m_sel = 0; m_div = 2'b11; m_settle = 0;
        m_wait = 0; m_fault = 0; m_switches = 0;
        for (int i = 0; i < SYNC_STAGES; i++) begin
            m_hs_line[i] = 0;
            m_ls_line[i] = 1;
        end
    endtask

    initial model_reset();

    // Model: feedback seen through a SYNC_STAGES-deep delay line, counters as plain ints.
    always @(posedge lsclk_in) begin : model
        bit go, seen_hs, seen_ls, fb_hs, fb_ls;
        if (!rst_b) begin
            model_reset();
        end else begin
            go      = turbo_en && !host_req && !m_fault;
            seen_hs = m_hs_line[SYNC_STAGES-1] && !m_ls_line[SYNC_STAGES-1];
            seen_ls = m_ls_line[SYNC_STAGES-1] && !m_hs_line[SYNC_STAGES-1];
            fb_hs   = (sw_mode == 0) ? m_sel : 1'b0;
            fb_ls   = (sw_mode == 0) ? !m_sel : 1'b1;
            if (m_phase == M_LS) begin
                m_div = cpuclk_div_cfg;
                if (m_settle >= SETTLE_CYCLES && go) begin
                    m_phase = M_TO_HS; m_sel = 1; m_wait = 0;
                end
                m_settle = (m_settle + 1 > SETTLE_CYCLES) ? SETTLE_CYCLES : m_settle + 1;
            end else if (m_phase == M_TO_HS) begin
                if (!go) begin
                    m_phase = M_TO_LS; m_sel = 0; m_wait = 0;
                end else if (seen_hs) begin
                    m_phase = M_HS;
                end else if (m_wait + 1 >= TIMEOUT) begin
                    m_fault = 1; m_phase = M_TO_LS; m_sel = 0;
                end else begin
                    m_wait++;
                end
            end else if (m_phase == M_HS) begin
                if (!go) begin
                    m_phase = M_TO_LS; m_sel = 0; m_wait = 0;
                    m_switches = (m_switches < 255) ? m_switches + 1 : 255;
                end
            end else begin
                if (seen_ls) begin
                    m_phase = M_LS; m_settle = 0;
                end else if (m_wait + 1 >= TIMEOUT) begin
                    m_fault = 1;
                end else begin
                    m_wait++;
                end
            end
            for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                m_hs_line[i] = m_hs_line[i-1];
                m_ls_line[i] = m_ls_line[i-1];
            end
            m_hs_line[0] = fb_hs;
            m_ls_line[0] = fb_ls;
        end
        #2;
        check("cyc_hsclk_sel", 32'(hsclk_sel), 32'(m_sel));
        check("cyc_div_sel", 32'(cpuclk_div_sel), 32'(m_div));
        check("cyc_host_ready", 32'(host_ready), 32'(m_phase == M_LS && host_req));
        check("cyc_fault", 32'(switch_fault), 32'(m_fault));
        check("cyc_sw_count", 32'(sw_count), 32'(m_switches));
        check("cyc_state", 32'(state_dbg), 32'(m_phase));
    end

    task automatic step();
        @(posedge lsclk_in);
        #3;
    endtask

    task automatic wait_state(input logic [1:0] s, input int max, input string name);
        int n = 0;
        while (state_dbg !== s && n < max) begin
            step();
            n++;
        end
        check(name, 32'(state_dbg), 32'(s));
    endtask

    initial begin
        int n;
        rst_b = 1'b0; turbo_en = 1'b1; host_req = 1'b0; cpuclk_div_cfg = 2'b01;
        step(); step();
        check("rst_sel", 32'(hsclk_sel), 32'd0);
        check("rst_div", 32'(cpuclk_div_sel), 32'd3);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_fault", 32'(switch_fault), 32'd0);
        check("rst_count", 32'(sw_count), 32'd0);
        host_req = 1'b1; #1;
        check("rst_host_ready", 32'(host_ready), 32'd1);
        host_req = 1'b0; #1;
        rst_b = 1'b1;

        // LS -> HS latency
        step(); check("e1_sel", 32'(hsclk_sel), 32'd0);
        step(); check("e2_sel", 32'(hsclk_sel), 32'd0);
        step(); check("e3_sel", 32'(hsclk_sel), 32'd1);
        check("e3_state", 32'(state_dbg), 32'd1);
        step(); step(); check("e5_state", 32'(state_dbg), 32'd1);
        step(); check("e6_state", 32'(state_dbg), 32'd2);
        check("e6_div", 32'(cpuclk_div_sel), 32'd1);

        // HS -> LS on host request
        host_req = 1'b1;
        step(); check("hl_sel", 32'(hsclk_sel), 32'd0);
        check("hl_count", 32'(sw_count), 32'd1);
        check("hl_ready0", 32'(host_ready), 32'd0);
        step(); step(); check("hl_ready2", 32'(host_ready), 32'd0);
        step(); check("hl_ready3", 32'(host_ready), 32'd1);
        host_req = 1'b0;

        // Abort in TO_HS
        wait_state(2'b01, 10, "ab_to_hs");
        turbo_en = 1'b0;
        step(); check("ab_state", 32'(state_dbg), 32'd3);
        check("ab_sel", 32'(hsclk_sel), 32'd0);
        wait_state(2'b00, 10, "ab_ls");
        check("ab_count", 32'(sw_count), 32'd1);
        check("ab_fault", 32'(switch_fault), 32'd0);

        // Divider only follows cfg in LS
        cpuclk_div_cfg = 2'b00; turbo_en = 1'b1;
        wait_state(2'b10, 20, "dv_hs");
        check("dv_div_hs", 32'(cpuclk_div_sel), 32'd0);
        cpuclk_div_cfg = 2'b10;
        step(); step(); step();
        check("dv_div_hold", 32'(cpuclk_div_sel), 32'd0);
        host_req = 1'b1;
        wait_state(2'b00, 20, "dv_ls");
        check("dv_div_entry", 32'(cpuclk_div_sel), 32'd0);
        step(); check("dv_div_ls", 32'(cpuclk_div_sel), 32'd2);
        host_req = 1'b0;

        // Acknowledge timeout
        sw_mode = 1;
        wait_state(2'b01, 20, "to_to_hs");
        repeat (14) step();
        check("to_state14", 32'(state_dbg), 32'd1);
        check("to_fault14", 32'(switch_fault), 32'd0);
        step(); check("to_fault15", 32'(switch_fault), 32'd1);
        check("to_state15", 32'(state_dbg), 32'd3);
        check("to_sel15", 32'(hsclk_sel), 32'd0);
        step(); check("to_ls", 32'(state_dbg), 32'd0);
        repeat (20) step();
        check("to_stuck_sel", 32'(hsclk_sel), 32'd0);
        check("to_stuck_state", 32'(state_dbg), 32'd0);
        rst_b = 1'b0; sw_mode = 0;
        step(); rst_b = 1'b1;
        check("to_fault_clr", 32'(switch_fault), 32'd0);

        // Switch counter saturation
        for (int k = 0; k < 300; k++) begin
            wait_state(2'b10, 20, "sat_hs");
            host_req = 1'b1;
            n = 0;
            while (!host_ready && n < 20) begin
                step();
                n++;
            end
            check("sat_ready", 32'(host_ready), 32'd1);
            host_req = 1'b0;
        end
        check("sat_count", 32'(sw_count), 32'd255);

        // Asynchronous reset mid TO_HS
        wait_state(2'b01, 20, "ar_to_hs");
        rst_b = 1'b0; #1;
        check("ar_sel", 32'(hsclk_sel), 32'd0);
        check("ar_state", 32'(state_dbg), 32'd0);
        check("ar_div", 32'(cpuclk_div_sel), 32'd3);
        check("ar_count", 32'(sw_count), 32'd0);
        check("ar_fault", 32'(switch_fault), 32'd0);
        step(); rst_b = 1'b1;
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clksel_ctrl.md
# clksel_ctrl

Sequencer that drives the `hsclk_sel` request of the glitch-free PHI2 clock switch. It runs in the host (`lsclk_in`) domain and decides, cycle by cycle, whether the accelerated CPU may run on the high-speed clock or must drop to host speed for host-bus accesses. It waits for the switch's own `hsclk_selected`/`lsclk_selected` feedback before declaring a speed stable. It also owns the safe update of the high-speed divider select, a minimum low-speed dwell, a handshake-timeout fault and a switch counter.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth for the feedback inputs; must be >= 2.
- SETTLE_CYCLES, 2: minimum `lsclk_in` cycles spent in LS before any HS request; 1..15.
- TIMEOUT, 15: maximum `lsclk_in` cycles allowed for a switch acknowledge; 1..255.

Ports:
- lsclk_in  in  1  host PHI2 clock; all state updates on posedge.
- rst_b  in  1  asynchronous, active-low reset.
- turbo_en  in  1  configuration: high-speed operation permitted.
- host_req  in  1  the CPU's current access needs the host bus; level, held until `host_ready` is seen.
- cpuclk_div_cfg  in  2  requested high-speed divider (00 /1, 01 /2, 1x /4).
- hsclk_selected  in  1  switch feedback; asynchronous to `lsclk_in`.
- lsclk_selected  in  1  switch feedback; asynchronous to `lsclk_in`.
- hsclk_sel  out  1  request to the clock switch (1 = high speed).
- cpuclk_div_sel  out  2  divider select to the switch; changes only in LS.
- host_ready  out  1  the CPU is confirmed on the host clock and `host_req` is pending.
- switch_fault  out  1  sticky; an acknowledge timed out.
- sw_count  out  8  number of HS->LS switches, saturating.
- state_dbg  out  2  FSM state (00 LS, 01 TO_HS, 10 HS, 11 TO_LS).

## Operation
- Feedback inputs pass through SYNC_STAGES flops each, giving `hs_s` and `ls_s`.
  - Reset values: `hs_s` = 0, `ls_s` = 1.
- `ls_ok` = `ls_s` & !`hs_s`. `hs_ok` = `hs_s` & !`ls_s`.
- `go_hs` = `turbo_en` & !`host_req` & !`switch_fault`.

FSM states (all registered):
- LS: `hsclk_sel` = 0.
  - `cpuclk_div_sel` <= `cpuclk_div_cfg` every cycle.
  - `settle_cnt` increments, saturating at SETTLE_CYCLES.
  - If `settle_cnt` == SETTLE_CYCLES and `go_hs`: go to TO_HS, set `hsclk_sel` = 1, clear `to_cnt`.
- TO_HS:
  - If !`go_hs`: go to TO_LS, set `hsclk_sel` = 0, clear `to_cnt`. This is an abort; `sw_count` is not incremented.
  - Else if `hs_ok`: go to HS.
  - Else if `to_cnt` == TIMEOUT-1: set `switch_fault`, go to TO_LS, set `hsclk_sel` = 0.
  - Otherwise `to_cnt`++.
- HS: if !`go_hs`, go to TO_LS, set `hsclk_sel` = 0, clear `to_cnt`, and increment `sw_count` (saturates at 255).
- TO_LS:
  - If `ls_ok`: go to LS and clear `settle_cnt`.
  - Else if `to_cnt` == TIMEOUT-1: set `switch_fault` and remain in TO_LS. HS is never re-entered without `ls_ok`.
  - Otherwise `to_cnt`++.
- `host_ready` = (state == LS) & `host_req`. This is combinational from registered state.
- Priority within TO_HS: abort > acknowledge > timeout.
- `switch_fault` clears only on reset. While it is set, `go_hs` = 0, so the block stays in LS or TO_LS.
- `cpuclk_div_cfg` changes outside LS are ignored until the next LS cycle.

## Timing
- Reset values: state LS, `hsclk_sel` 0, `cpuclk_div_sel` 11, `settle_cnt` 0, `to_cnt` 0, `switch_fault` 0, `sw_count` 0.
- Derived reset outputs: `host_ready` = `host_req`; `state_dbg` = 00.
- LS->HS latency: SETTLE_CYCLES+1 edges to raise `hsclk_sel`, then at least SYNC_STAGES+1 edges to enter HS.
- HS->LS: `hsclk_sel` falls on the first edge that samples `host_req` = 1.
  - `host_ready` rises at least SYNC_STAGES+1 edges after that, once `ls_ok` is seen.
- `host_req` rising while in LS: `host_ready` rises combinationally in the same cycle.
- Reset asserted mid-switch: all registers return to reset values immediately and `hsclk_sel` drops asynchronously.

## Test plan
- Reset, then turbo_en=1, host_req=0, ideal switch model with zero delay -> `hsclk_sel` rises at edge 3; state HS at edge 6; `cpuclk_div_sel` equals the cfg value sampled at edge 2.
- In HS, pulse host_req high -> `hsclk_sel`=0 at the next edge; `host_ready`=1 at edge +3 after the model swaps; `sw_count`=1.
- In TO_HS, drop turbo_en before the acknowledge -> TO_LS, then LS; `sw_count` unchanged; no fault.
- Switch model never acknowledges HS -> after 15 cycles in TO_HS, `switch_fault`=1, LS reached; turbo_en=1 no longer raises `hsclk_sel`.
- Change cpuclk_div_cfg 00->10 while in HS -> `cpuclk_div_sel` stays 00 until LS is re-entered, then becomes 10.
- 300 HS->LS cycles -> `sw_count` saturates at 255; assert rst_b=0 mid-TO_HS -> all outputs return to reset values.
